// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, clamped step, wrap or
// saturate behaviour, registered overflow/underflow pulses and a cascade tc flag.
module updown_counter_param #(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             en,
  input  logic             ud,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];
  // Modulus is one wider than the count so MAX_VAL = 2**WIDTH-1 still works.
  localparam logic [WIDTH:0]   MODV = {1'b0, MAXV} + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_up_wrap;
  logic [WIDTH:0]   w_dn_wrap;
  logic             w_over;
  logic             w_under;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  assign w_step    = (step > MAXV) ? MAXV : step;
  assign w_sum     = {1'b0, r_count} + {1'b0, w_step};
  assign w_over    = (w_sum > {1'b0, MAXV});
  assign w_under   = (w_step > r_count);
  assign w_up_wrap = w_sum - MODV;
  // count + modulus - step never exceeds WIDTH+1 bits since count <= MAX_VAL.
  assign w_dn_wrap = {1'b0, r_count} + MODV - {1'b0, w_step};

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
    end else if (ld) begin
      w_count_nxt = (data > MAXV) ? MAXV : data;
    end else if (en) begin
      if (ud) begin
        if (w_over) begin
          w_ovf_nxt   = 1'b1;
          w_count_nxt = SATURATE ? MAXV : w_up_wrap[WIDTH-1:0];
        end else begin
          w_count_nxt = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_under) begin
          w_unf_nxt   = 1'b1;
          w_count_nxt = SATURATE ? '0 : w_dn_wrap[WIDTH-1:0];
        end else begin
          w_count_nxt = r_count - w_step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;
  assign unf   = r_unf;
  assign tc    = en & ((ud & (r_count == MAXV)) | (~ud & (r_count == '0)));

endmodule
